// File: rtl/ex_fifo_rd_burst.sv
// ex_fifo_rd_burst
// Read-side drain stage for ex_fifo, entirely in the FIFO read clock domain.
// It pulls words from the FIFO read port and hides the FIFO's one-cycle read
// latency behind a 3-entry prefetch buffer. Words leave as a valid/ready
// stream framed into fixed-length bursts, with a programmable idle gap
// between bursts.
//
// Ports
//   rd_clk, rd_rst        read-domain clock, async active-high reset
//   en                    start/continue bursting
//   fifo_rd_en            read request to ex_fifo rd_en
//   fifo_rd_data          ex_fifo rd_data (valid the cycle after a read)
//   fifo_rd_empty         ex_fifo rd_empty
//   m_valid/m_ready       stream handshake
//   m_data                stream word (head of the prefetch buffer)
//   m_sop/m_eop           first/last word of a burst, qualified by m_valid
//   burst_cnt             completed bursts, wraps at 65535 -> 0
//   busy                  FSM not idle, or prefetched words are held
module ex_fifo_rd_burst #(
    parameter int FIFO_WIDTH_Bit = 16,
    parameter int BURST_LEN      = 8,
    parameter int GAP_CYC        = 4
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      en,
    output logic                      fifo_rd_en,
    input  logic [FIFO_WIDTH_Bit-1:0] fifo_rd_data,
    input  logic                      fifo_rd_empty,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [FIFO_WIDTH_Bit-1:0] m_data,
    output logic                      m_sop,
    output logic                      m_eop,
    output logic [15:0]               burst_cnt,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    localparam logic [7:0] BEAT_LAST = 8'(BURST_LEN - 1);
    // With no gap the GAP state is unreachable; keep the compare value legal.
    localparam logic [7:0] GAP_LAST  = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

    state_t state, state_next;
    logic [7:0]  beat, beat_next;
    logic [7:0]  gap_cnt, gap_cnt_next;
    logic [15:0] burst_cnt_next;

    logic [FIFO_WIDTH_Bit-1:0] buf_mem [3];
    logic [1:0] head, tail, occ;
    logic       inflight;
    logic       push, pop, en_fetch, room;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve room for the word already in flight: a new read is allowed only
    // if occupancy plus the outstanding read, less this cycle's pop, stays
    // below the buffer depth. Reads are blocked while reset is held so a
    // request in the reset cycle never reaches the FIFO.
    always_comb begin
        en_fetch   = en || (state != IDLE);
        room       = ({1'b0, occ} + {2'b00, inflight}) < (3'd3 + {2'b00, pop});
        fifo_rd_en = !rd_rst && !fifo_rd_empty && en_fetch && room;
    end

    always_comb begin
        m_valid = (state == BURST) && (occ != 2'd0);
        pop     = m_valid && m_ready;
        push    = inflight;
        m_data  = buf_mem[head];
        m_sop   = m_valid && (beat == 8'd0);
        m_eop   = m_valid && (beat == BEAT_LAST);
        busy    = (state != IDLE) || (occ != 2'd0);
    end

    // Prefetch buffer: circular, data from a read issued last cycle is
    // written at this edge. A simultaneous push and pop leaves occ unchanged.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            inflight <= fifo_rd_en;
            if (push) begin
                buf_mem[tail] <= fifo_rd_data;
                tail          <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: ;
            endcase
        end
    end

    // The read throttle guarantees the buffer cannot overflow.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            assert (!(push && !pop && occ == 2'd3));
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state     <= IDLE;
            beat      <= 8'd0;
            gap_cnt   <= 8'd0;
            burst_cnt <= 16'd0;
        end else begin
            state     <= state_next;
            beat      <= beat_next;
            gap_cnt   <= gap_cnt_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    // beat only advances on a pop, so an empty FIFO mid-burst simply stalls
    // the burst. en is only looked at in IDLE and at the end of a gap, which
    // lets a started burst always run to BURST_LEN words.
    always_comb begin
        state_next     = state;
        beat_next      = beat;
        gap_cnt_next   = gap_cnt;
        burst_cnt_next = burst_cnt;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = BURST;
                    beat_next  = 8'd0;
                end
            end
            BURST: begin
                if (pop) begin
                    if (beat == BEAT_LAST) begin
                        beat_next      = 8'd0;
                        burst_cnt_next = burst_cnt + 16'd1;
                        if (GAP_CYC > 0) begin
                            state_next   = GAP;
                            gap_cnt_next = 8'd0;
                        end else begin
                            state_next = en ? BURST : IDLE;
                        end
                    end else begin
                        beat_next = beat + 8'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_next = 8'd0;
                    state_next   = en ? BURST : IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ex_fifo_rd_burst.sv
// tb_ex_fifo_rd_burst
// Directed bench for ex_fifo_rd_burst. A behavioural FIFO model feeds the
// main instance (BURST_LEN=8, GAP_CYC=4); a counting source feeds a second
// instance with GAP_CYC=0 for the back-to-back case. Inputs change 1 ns after
// the rising edge, stream outputs are logged on the falling edge.
module tb_ex_fifo_rd_burst;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          en = 1'b0;
    logic          m_ready = 1'b1;
    logic          fifo_rd_en, fifo_rd_empty, m_valid, m_sop, m_eop, busy;
    logic [W-1:0]  fifo_rd_data = '0;
    logic [W-1:0]  m_data;
    logic [15:0]   burst_cnt;

    logic          rst0 = 1'b1;
    logic          en0 = 1'b0;
    logic          rd_en0, empty0, valid0, sop0, eop0, busy0;
    logic [W-1:0]  data0 = '0;
    logic [W-1:0]  data_out0;
    logic [15:0]   cnt0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int fmem [0:1023];
    int fwr = 0;
    int frd = 0;
    logic flush = 1'b0;
    int rd_viol = 0;

    int  log_data [0:1023];
    bit  log_sop  [0:1023];
    bit  log_eop  [0:1023];
    int  log_cyc  [0:1023];
    int  log_n = 0;
    bit  stall_prev = 0;
    logic [W-1:0] prev_data;
    logic prev_sop, prev_eop;
    int  stab_viol = 0;
    int  base_frd = 0, base_log = 0, outst = 0, max_outst = 0;
    bit  ready_toggle = 0;

    int src0 = 0;
    int pops0 = 0, seq_err0 = 0, first_cyc0 = 0, last_cyc0 = 0;

    assign fifo_rd_empty = (frd == fwr);
    assign empty0        = (src0 >= 256);

    ex_fifo_rd_burst #(.FIFO_WIDTH_Bit(W), .BURST_LEN(8), .GAP_CYC(4)) u_dut (
        .rd_clk(clk), .rd_rst(rd_rst), .en(en),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sop(m_sop), .m_eop(m_eop), .burst_cnt(burst_cnt), .busy(busy)
    );

    ex_fifo_rd_burst #(.FIFO_WIDTH_Bit(W), .BURST_LEN(8), .GAP_CYC(0)) u_dut0 (
        .rd_clk(clk), .rd_rst(rst0), .en(en0),
        .fifo_rd_en(rd_en0), .fifo_rd_data(data0), .fifo_rd_empty(empty0),
        .m_valid(valid0), .m_ready(1'b1), .m_data(data_out0),
        .m_sop(sop0), .m_eop(eop0), .burst_cnt(cnt0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // FIFO model: one-cycle read latency, flush on request.
    always @(posedge clk) begin
        if (flush) begin
            frd <= fwr;
        end else if (fifo_rd_en) begin
            if (fifo_rd_empty) begin
                rd_viol++;
            end else begin
                fifo_rd_data <= W'(fmem[frd]);
                frd          <= frd + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rd_en0 && !empty0) begin
            data0 <= W'(src0);
            src0  <= src0 + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready = ready_toggle ? ~m_ready : 1'b1;
    end

    // Stream monitor: log pops, hold-while-stalled, and words held inside
    // the block (taken from the FIFO but not yet popped).
    always @(negedge clk) begin
        if (rd_rst) begin
            stall_prev = 0;
            base_frd   = frd;
            base_log   = log_n;
        end else begin
            outst = (frd - base_frd) - (log_n - base_log);
            if (outst > max_outst) max_outst = outst;
            if (stall_prev && (m_valid !== 1'b1 || m_data !== prev_data ||
                               m_sop !== prev_sop || m_eop !== prev_eop))
                stab_viol++;
            if (m_valid && m_ready) begin
                log_data[log_n] = int'(m_data);
                log_sop[log_n]  = m_sop;
                log_eop[log_n]  = m_eop;
                log_cyc[log_n]  = cyc;
                log_n++;
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_sop   = m_sop;
            prev_eop   = m_eop;
        end
    end

    always @(negedge clk) begin
        if (!rst0 && valid0) begin
            if (data_out0 != W'(pops0)) seq_err0++;
            if (sop0 != ((pops0 % 8) == 0)) seq_err0++;
            if (eop0 != ((pops0 % 8) == 7)) seq_err0++;
            if (pops0 == 0) first_cyc0 = cyc;
            last_cyc0 = cyc;
            pops0++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input int v);
        fmem[fwr] = v;
        fwr++;
    endtask

    task automatic wait_pops(input int target, input int budget, input string tag);
        int k = 0;
        while (log_n < target && k < budget) begin
            step(1);
            k++;
        end
        if (log_n < target) checkOutput(tag, log_n, target);
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        en     = 1'b0;
        flush  = 1'b1;
        step(1);
        flush  = 1'b0;
        step(1);
        rd_rst = 1'b0;
    endtask

    task automatic applyStimulus();
        int base, c_en, fbase, exp_word;

        // Reset state, even with en high and a word waiting in the FIFO.
        en = 1'b1;
        push_word(16'hAAAA);
        #3;
        checkOutput("rst_fifo_rd_en", fifo_rd_en, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_sop", m_sop, 0);
        checkOutput("rst_m_eop", m_eop, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_burst_cnt", burst_cnt, 0);
        checkOutput("rst_busy", busy, 0);
        step(1);
        do_reset();

        // Two bursts of 0..15 with a 4-cycle gap.
        base = log_n;
        for (int i = 0; i < 16; i++) push_word(i);
        c_en = cyc;
        en   = 1'b1;
        wait_pops(base + 16, 100, "t1_timeout");
        step(3);
        checkOutput("t1_latency", log_cyc[base] - c_en, 2);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("t1_data%0d", i), log_data[base+i], i);
        checkOutput("t1_sop0", log_sop[base], 1);
        checkOutput("t1_sop8", log_sop[base+8], 1);
        checkOutput("t1_sop1", log_sop[base+1], 0);
        checkOutput("t1_eop7", log_eop[base+7], 1);
        checkOutput("t1_eop15", log_eop[base+15], 1);
        checkOutput("t1_eop6", log_eop[base+6], 0);
        checkOutput("t1_rate", log_cyc[base+7] - log_cyc[base], 7);
        checkOutput("t1_gap", log_cyc[base+8] - log_cyc[base+7], 5);
        checkOutput("t1_burst_cnt", burst_cnt, 2);
        checkOutput("t1_valid_after", m_valid, 0);

        // Same traffic with m_ready toggling every cycle.
        do_reset();
        base = log_n;
        ready_toggle = 1;
        for (int i = 0; i < 16; i++) push_word(16 + i);
        en = 1'b1;
        wait_pops(base + 16, 200, "t2_timeout");
        step(4);
        ready_toggle = 0;
        checkOutput("t2_count", log_n - base, 16);
        checkOutput("t2_data0", log_data[base], 16);
        checkOutput("t2_data9", log_data[base+9], 25);
        checkOutput("t2_data15", log_data[base+15], 31);
        checkOutput("t2_sop8", log_sop[base+8], 1);
        checkOutput("t2_eop15", log_eop[base+15], 1);
        checkOutput("t2_burst_cnt", burst_cnt, 2);
        step(2);

        // FIFO runs dry after three words, refilled 20 cycles later.
        do_reset();
        base = log_n;
        for (int i = 0; i < 3; i++) push_word(100 + i);
        en = 1'b1;
        step(20);
        checkOutput("t3_partial", log_n - base, 3);
        checkOutput("t3_valid_dry", m_valid, 0);
        checkOutput("t3_busy_dry", busy, 1);
        for (int i = 3; i < 8; i++) push_word(100 + i);
        wait_pops(base + 8, 50, "t3_timeout");
        step(3);
        checkOutput("t3_data3", log_data[base+3], 103);
        checkOutput("t3_sop3", log_sop[base+3], 0);
        checkOutput("t3_eop2", log_eop[base+2], 0);
        checkOutput("t3_eop7", log_eop[base+7], 1);
        checkOutput("t3_data7", log_data[base+7], 107);
        checkOutput("t3_burst_cnt", burst_cnt, 1);

        // en dropped after the first word: burst completes, 3 words held.
        do_reset();
        base  = log_n;
        fbase = frd;
        for (int i = 0; i < 40; i++) push_word(200 + i);
        en = 1'b1;
        wait_pops(base + 1, 20, "t4_sop_timeout");
        en = 1'b0;
        step(30);
        checkOutput("t4_count", log_n - base, 8);
        checkOutput("t4_data7", log_data[base+7], 207);
        checkOutput("t4_burst_cnt", burst_cnt, 1);
        checkOutput("t4_valid_idle", m_valid, 0);
        checkOutput("t4_busy_idle", busy, 1);
        checkOutput("t4_rd_en_idle", fifo_rd_en, 0);
        checkOutput("t4_fetched", frd - fbase, 11);
        en = 1'b1;
        wait_pops(base + 9, 20, "t4_resume_timeout");
        checkOutput("t4_resume_data", log_data[base+8], 208);
        checkOutput("t4_resume_sop", log_sop[base+8], 1);

        // Reset pulse while word 5 of a burst is presented.
        do_reset();
        base = log_n;
        for (int i = 0; i < 16; i++) push_word(300 + i);
        en = 1'b1;
        wait_pops(base + 5, 30, "t6_timeout");
        rd_rst = 1'b1;
        #1;
        checkOutput("t6_valid", m_valid, 0);
        checkOutput("t6_rd_en", fifo_rd_en, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_sop", m_sop, 0);
        checkOutput("t6_data", m_data, 0);
        step(2);
        exp_word = fmem[frd];
        base     = log_n;
        rd_rst   = 1'b0;
        wait_pops(base + 1, 20, "t6_restart_timeout");
        checkOutput("t6_restart_data", log_data[base], exp_word);
        checkOutput("t6_restart_sop", log_sop[base], 1);
        step(2);

        // GAP_CYC=0 instance: 256 words, 32 back-to-back bursts.
        rst0 = 1'b0;
        en0  = 1'b1;
        for (int k = 0; k < 400 && pops0 < 256; k++) step(1);
        step(3);
        checkOutput("t5_pops", pops0, 256);
        checkOutput("t5_seq_err", seq_err0, 0);
        checkOutput("t5_rate", last_cyc0 - first_cyc0, 255);
        checkOutput("t5_burst_cnt", cnt0, 32);
    endtask

    initial begin
        applyStimulus();
        checkOutput("rd_en_while_empty", rd_viol, 0);
        checkOutput("stall_stability", stab_viol, 0);
        checkOutput("max_held_le3", (max_outst <= 3), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_fifo_rd_burst.md
# ex_fifo_rd_burst

Read-side drain stage for `ex_fifo`, operating entirely in the FIFO read clock domain. It pulls words from the FIFO read port (`rd_en`/`rd_data`/`rd_empty`) and absorbs the FIFO's one-cycle read latency in a 3-entry prefetch buffer. It presents the words as a valid/ready stream framed into fixed-length bursts with start and end markers. A programmable idle gap separates consecutive bursts, so the downstream consumer sees clean packet boundaries at full throughput inside a burst.

## Interface
- `FIFO_WIDTH_Bit`, 16: data width; must match `ex_fifo`.
- `BURST_LEN`, 8: words per burst, 2..256.
- `GAP_CYC`, 4: idle cycles forced between bursts, 0..255.
- `rd_clk` in 1: read-domain clock; all logic is on its rising edge.
- `rd_rst` in 1: asynchronous, active-high reset.
- `en` in 1: start/continue bursting.
- `fifo_rd_en` out 1: read request to `ex_fifo` `rd_en`.
- `fifo_rd_data` in FIFO_WIDTH_Bit: from `ex_fifo` `rd_data`.
- `fifo_rd_empty` in 1: from `ex_fifo` `rd_empty`.
- `m_valid` out 1: stream word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out FIFO_WIDTH_Bit: stream word.
- `m_sop` out 1: first word of burst; qualified by `m_valid`.
- `m_eop` out 1: last word of burst; qualified by `m_valid`.
- `burst_cnt` out 16: number of completed bursts; wraps at 65535 → 0.
- `busy` out 1: high when state is not IDLE or the buffer is non-empty.

## Operation
- FIFO read contract:
  - When `fifo_rd_en` is high at an edge with `fifo_rd_empty` low, `fifo_rd_data` is valid for the following cycle.
  - The block captures that data at the next edge.
  - `fifo_rd_en` is never driven high while `fifo_rd_empty` is high.
- Prefetch:
  - `fifo_rd_en` = `!fifo_rd_empty && en_fetch && (occ + inflight − pop) < 3`.
  - `occ`: buffer occupancy, 0..3.
  - `inflight`: a 1-bit flag meaning a read was issued last cycle.
  - `pop`: `m_valid && m_ready`.
  - `en_fetch` is `en || state != IDLE`.
  - The buffer never overflows; an overflow is an assertion failure.
- Buffer is FIFO-ordered, 3 entries; `m_data` is the head entry.
- `m_valid` = `state == BURST && occ != 0`.
- FSM:
  - IDLE → BURST when `en` = 1. `beat` is set to 0.
  - BURST: each pop increments `beat`.
    - When the pop has `beat == BURST_LEN−1`: `beat` → 0 and `burst_cnt` +1.
    - Next state is GAP if GAP_CYC > 0.
    - Otherwise next state is BURST if `en` = 1, else IDLE.
  - GAP: `gap_cnt` counts up from 0.
    - When `gap_cnt == GAP_CYC−1`: next state is BURST if `en` = 1, else IDLE.
    - Prefetch continues during GAP.
- `m_sop` = `m_valid && beat == 0`.
- `m_eop` = `m_valid && beat == BURST_LEN−1`.
- Deasserting `en` mid-burst does not truncate the burst: it completes all BURST_LEN words, then returns to IDLE after the gap.
- Prefetched words are held across IDLE. They are not dropped.
- FIFO going empty mid-burst: `m_valid` drops and `beat` holds; the burst resumes when data arrives.
- `m_valid`/`m_data`/`m_sop`/`m_eop` are held stable while `m_valid && !m_ready`.

## Timing
- Reset, asynchronous while `rd_rst` is high:
  - `fifo_rd_en` = 0, `m_valid` = 0, `m_sop` = 0, `m_eop` = 0, `m_data` = 0, `burst_cnt` = 0, `busy` = 0.
  - `occ` = 0, `inflight` = 0, state = IDLE, `beat` = 0, `gap_cnt` = 0.
  - Release of reset is synchronous to `rd_clk` via the integrator's synchronizer.
- Reset mid-burst discards all buffered and in-flight words; a FIFO read issued in the reset cycle is lost.
- First-word latency: with `fifo_rd_empty` and `en` first seen at edge k (`fifo_rd_en` high in that cycle), data is captured at k+1 and `m_valid` goes high after k+1.
- Throughput: one word per cycle sustained inside a burst while the FIFO is non-empty and `m_ready` = 1.
- Burst spacing: with continuous data, the first word of the next burst is valid exactly GAP_CYC cycles after the `m_eop` pop edge.
- Simultaneous capture and pop in one cycle: `occ` is unchanged.
- `burst_cnt` updates on the same edge as the `m_eop` pop.

## Test plan
- Reset, FIFO preloaded with 0..15, `en`=1, `m_ready`=1, BURST_LEN=8, GAP_CYC=4 → two bursts 0–7 and 8–15; `m_sop` on 0 and 8, `m_eop` on 7 and 15; exactly 4 idle cycles between 7 and 8; `burst_cnt`=2.
- Same preload, `m_ready` toggling 1/0 every cycle → same sequence with no loss or duplication; outputs stable while stalled; `fifo_rd_en` never high while occupancy+inflight would exceed 3.
- FIFO holds 0..2 and then goes empty mid-burst; 5 more words are written 20 cycles later → `m_valid` low for the gap in data; `beat` resumes at 3; `m_eop` on the 8th word.
- `en` dropped after `m_sop` of burst 1, 40 words available → the burst completes 8 words, then state goes IDLE and `m_valid` stays 0; buffer holds ≤3 prefetched words; `busy`=1 while the buffer is non-empty.
- GAP_CYC=0, 256 words in the FIFO → 32 back-to-back bursts at 1 word/cycle; `burst_cnt`=32.
- `rd_rst` pulsed during word 5 of a burst → all outputs 0 immediately; after release a new burst starts with `m_sop` on the next FIFO word.
